// File: rtl/riscv_core.sv
// Single-cycle RV32I R/I-type + MUL core with a fixed internal instruction ROM.
// Fetch, decode, execute and register writeback all complete within one clock.

module riscv_regfile #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4:0]            raddr1_i,
  input  logic [4:0]            raddr2_i,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic [DATA_WIDTH-1:0] rdata2_o,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i
);

  logic [DATA_WIDTH-1:0] registers [0:31];

  // Reset seeds each xi with i so the ROM program has known operands.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        registers[i] <= DATA_WIDTH'(i);
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      registers[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? '0 : registers[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? '0 : registers[raddr2_i];

endmodule

module riscv_core #(
  parameter int DATA_WIDTH = 32,
  parameter int IMEM_DEPTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  zero_flag_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [31:0]           instruction_o
);

  localparam int IDX_W = $clog2(IMEM_DEPTH);
  localparam logic [6:0] OP_REG = 7'h33;
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [IDX_W-1:0]      romIndex;
  logic [31:0]           instr;
  logic [6:0]            opcode, funct7;
  logic [2:0]            funct3;
  logic [4:0]            rd, rs1, rs2;
  logic [DATA_WIDTH-1:0] rs1Data, rs2Data, immI, opB, aluResult;
  logic [4:0]            shamt;
  logic                  regWrite;

  function automatic logic [31:0] romWord(input int unsigned idx);
    case (idx)
      0:       romWord = 32'h0094_0333;
      1:       romWord = 32'h40B5_03B3;
      2:       romWord = 32'h02D6_02B3;
      3:       romWord = 32'h0107_C733;
      4:       romWord = 32'h0139_18B3;
      5:       romWord = 32'h016A_DA33;
      6:       romWord = 32'h019C_7BB3;
      7:       romWord = 32'h01CD_ED33;
      default: romWord = NOP;
    endcase
  endfunction

  // Fetch ignores PC bits above the ROM index, so the program repeats on wrap.
  assign romIndex = pc_q[IDX_W+1:2];
  assign instr    = romWord(int'(romIndex));

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];
  assign immI   = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
  assign opB    = (opcode == OP_IMM) ? immI : rs2Data;
  assign shamt  = opB[4:0];

  riscv_regfile #(.DATA_WIDTH(DATA_WIDTH)) u_register_file (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rs1Data),
    .rdata2_o (rs2Data),
    .we_i     (regWrite),
    .waddr_i  (rd),
    .wdata_i  (aluResult)
  );

  // Unsupported encodings leave the result at zero and suppress the write.
  always_comb begin
    aluResult = '0;
    regWrite  = 1'b0;
    if (opcode == OP_REG) begin
      regWrite = 1'b1;
      case ({funct7, funct3})
        {7'h00, 3'd0}: aluResult = rs1Data + opB;
        {7'h00, 3'd1}: aluResult = rs1Data << shamt;
        {7'h00, 3'd2}: aluResult = {{(DATA_WIDTH-1){1'b0}}, $signed(rs1Data) < $signed(opB)};
        {7'h00, 3'd3}: aluResult = {{(DATA_WIDTH-1){1'b0}}, rs1Data < opB};
        {7'h00, 3'd4}: aluResult = rs1Data ^ opB;
        {7'h00, 3'd5}: aluResult = rs1Data >> shamt;
        {7'h00, 3'd6}: aluResult = rs1Data | opB;
        {7'h00, 3'd7}: aluResult = rs1Data & opB;
        {7'h20, 3'd0}: aluResult = rs1Data - opB;
        {7'h20, 3'd5}: aluResult = DATA_WIDTH'($signed(rs1Data) >>> shamt);
        {7'h01, 3'd0}: aluResult = rs1Data * opB;
        default:       regWrite  = 1'b0;
      endcase
    end else if (opcode == OP_IMM) begin
      regWrite = 1'b1;
      case (funct3)
        3'd0: aluResult = rs1Data + opB;
        3'd2: aluResult = {{(DATA_WIDTH-1){1'b0}}, $signed(rs1Data) < $signed(opB)};
        3'd3: aluResult = {{(DATA_WIDTH-1){1'b0}}, rs1Data < opB};
        3'd4: aluResult = rs1Data ^ opB;
        3'd6: aluResult = rs1Data | opB;
        3'd7: aluResult = rs1Data & opB;
        3'd1: begin
          if (funct7 == 7'h00) aluResult = rs1Data << shamt;
          else                 regWrite  = 1'b0;
        end
        default: begin
          if (funct7 == 7'h00)      aluResult = rs1Data >> shamt;
          else if (funct7 == 7'h20) aluResult = DATA_WIDTH'($signed(rs1Data) >>> shamt);
          else                      regWrite  = 1'b0;
        end
      endcase
    end
  end

  assign pc_d = pc_q + DATA_WIDTH'(4);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  assign pc_o          = pc_q;
  assign instruction_o = instr;
  assign zero_flag_o   = (aluResult == '0);

endmodule

// File: tb/tb_riscv_core.sv
// Randomized-reset bench for riscv_core against an instruction-level reference model.
// Register state is observed through the u_register_file hierarchy.

module tb_riscv_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        zeroFlag;
  logic [31:0] pc;
  logic [31:0] instruction;

  int total = 0;
  int bad   = 0;

  logic [31:0] refRegs [32];
  logic [31:0] refPc;
  logic [31:0] refRom  [64];

  riscv_core #(.DATA_WIDTH(32), .IMEM_DEPTH(64)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .zero_flag_o   (zeroFlag),
    .pc_o          (pc),
    .instruction_o (instruction)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Executes one instruction in the ISA's own terms: returns whether it writes and what.
  function automatic void execute(input logic [31:0] ins, output logic wr, output logic [31:0] res);
    logic [31:0] a, b;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    op  = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    a   = refRegs[ins[19:15]];
    b   = (op == 7'h13) ? {{20{ins[31]}}, ins[31:20]} : refRegs[ins[24:20]];
    wr  = 1'b0;
    res = 32'd0;
    if (op == 7'h33 || op == 7'h13) begin
      wr = 1'b1;
      if (op == 7'h33 && f7 == 7'h01 && f3 == 3'd0)       res = a * b;
      else if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0)  res = a - b;
      else if ((op == 7'h13 || f7 == 7'h00) && f3 == 3'd0) res = a + b;
      else if ((op == 7'h13 || f7 == 7'h00) && f3 == 3'd2) res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      else if ((op == 7'h13 || f7 == 7'h00) && f3 == 3'd3) res = (a < b) ? 32'd1 : 32'd0;
      else if ((op == 7'h13 || f7 == 7'h00) && f3 == 3'd4) res = a ^ b;
      else if ((op == 7'h13 || f7 == 7'h00) && f3 == 3'd6) res = a | b;
      else if ((op == 7'h13 || f7 == 7'h00) && f3 == 3'd7) res = a & b;
      else if (f7 == 7'h00 && f3 == 3'd1)                  res = a << b[4:0];
      else if (f7 == 7'h00 && f3 == 3'd5)                  res = a >> b[4:0];
      else if (f7 == 7'h20 && f3 == 3'd5)                  res = $signed(a) >>> b[4:0];
      else wr = 1'b0;
    end
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 32; i++) refRegs[i] = i;
    refPc = 32'd0;
  endtask

  task automatic modelStep();
    logic        wr;
    logic [31:0] res;
    logic [31:0] ins;
    ins = refRom[refPc[7:2]];
    execute(ins, wr, res);
    if (wr && ins[11:7] != 5'd0) refRegs[ins[11:7]] = res;
    refPc = refPc + 32'd4;
  endtask

  task automatic compareAll(input string phase);
    logic        wr;
    logic [31:0] res;
    execute(refRom[refPc[7:2]], wr, res);
    checkOutput({phase, "_pc"}, pc, refPc);
    checkOutput({phase, "_instr"}, instruction, refRom[refPc[7:2]]);
    checkOutput({phase, "_zero"}, {31'd0, zeroFlag}, {31'd0, (res == 32'd0)});
    for (int i = 0; i < 32; i++) begin
      checkOutput($sformatf("%s_x%0d", phase, i), dut.u_register_file.registers[i], refRegs[i]);
    end
  endtask

  // One clock edge; the model advances only if reset was low at the edge.
  task automatic applyStimulus(input int cycles, input string phase);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      if (!rst) modelStep();
      #1;
      compareAll(phase);
    end
  endtask

  logic [31:0] directedReg [1:8];
  logic [31:0] directedVal [1:8];

  initial begin
    for (int i = 0; i < 64; i++) refRom[i] = 32'h0000_0013;
    refRom[0] = 32'h0094_0333; refRom[1] = 32'h40B5_03B3;
    refRom[2] = 32'h02D6_02B3; refRom[3] = 32'h0107_C733;
    refRom[4] = 32'h0139_18B3; refRom[5] = 32'h016A_DA33;
    refRom[6] = 32'h019C_7BB3; refRom[7] = 32'h01CD_ED33;
    directedReg[1] = 6;  directedVal[1] = 32'h0000_0011;
    directedReg[2] = 7;  directedVal[2] = 32'hFFFF_FFFF;
    directedReg[3] = 5;  directedVal[3] = 32'h0000_009C;
    directedReg[4] = 14; directedVal[4] = 32'h0000_001F;
    directedReg[5] = 17; directedVal[5] = 32'h0090_0000;
    directedReg[6] = 20; directedVal[6] = 32'h0000_0000;
    directedReg[7] = 23; directedVal[7] = 32'h0000_0018;
    directedReg[8] = 26; directedVal[8] = 32'h0000_001F;

    modelReset();
    rst = 1'b1;
    applyStimulus(5, "reset");
    checkOutput("reset_pc0", pc, 32'd0);
    checkOutput("reset_x8", dut.u_register_file.registers[8], 32'd8);
    checkOutput("reset_x31", dut.u_register_file.registers[31], 32'd31);
    checkOutput("reset_zero_add", {31'd0, zeroFlag}, 32'd0);
    #1 rst = 1'b0;

    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1, "prog");
      checkOutput($sformatf("edge%0d_dest", k), dut.u_register_file.registers[directedReg[k]], directedVal[k]);
      checkOutput($sformatf("edge%0d_pc", k), pc, 32'(k * 4));
    end
    checkOutput("nop_zero", {31'd0, zeroFlag}, 32'd1);
    applyStimulus(60, "wrap");

    for (int round = 0; round < 6; round++) begin
      applyStimulus($urandom_range(1, 90), "run");
      #($urandom_range(1, 3));
      rst = 1'b1;
      modelReset();
      #1;
      checkOutput("async_pc", pc, 32'd0);
      checkOutput("async_x6", dut.u_register_file.registers[6], 32'd6);
      applyStimulus($urandom_range(1, 2), "hold");
      #($urandom_range(1, 3));
      rst = 1'b0;
    end
    applyStimulus(10, "final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
